// File: rtl/pass_pkg.sv
// Shared constants and state type for the keypad entry stage.
package pass_pkg;
  localparam int          DIGIT_W   = 4;
  localparam logic [3:0]  MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {IDLE, ENTRY, FULL, DONE} entry_state_t;
endpackage

// File: rtl/pass_entry_if.sv
// Keypad levels in, packed digit buffer and one-cycle requests out.
interface pass_entry_if import pass_pkg::*; #(parameter int DIGITS = 4);
  logic                         key_digit;
  logic [DIGIT_W-1:0]           key_code;
  logic                         key_enter;
  logic                         key_change;
  logic                         key_back;
  logic                         key_clear;
  logic [DIGIT_W*DIGITS-1:0]    password;
  logic [$clog2(DIGITS+1)-1:0]  digit_cnt;
  logic                         confirmPass;
  logic                         changePass;
  logic                         entry_err;
  logic                         timeout;

  modport slave (
    input  key_digit, key_code, key_enter, key_change, key_back, key_clear,
    output password, digit_cnt, confirmPass, changePass, entry_err, timeout
  );
  modport master (
    output key_digit, key_code, key_enter, key_change, key_back, key_clear,
    input  password, digit_cnt, confirmPass, changePass, entry_err, timeout
  );
endinterface

// File: rtl/pass_entry_key_edge.sv
// Rising-edge detector over a vector of debounced key levels.
module key_edge #(parameter int W = 1) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] lvl,
  output logic [W-1:0] rise
);
  logic [W-1:0] prev;

  // prev resets low so a key held through reset still fires once
  always_ff @(posedge clk or negedge rst)
    if (!rst) prev <= '0;
    else      prev <= lvl;

  assign rise = lvl & ~prev;
endmodule

// File: rtl/pass_entry.sv
// Keypad entry stage: digit shift buffer plus confirm/change requests.
// Optional inactivity clear enabled by defining PASS_ENTRY_TIMEOUT_EN.
module pass_entry import pass_pkg::*; #(
  parameter int DIGITS         = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  pass_entry_if.slave bus
);
  localparam int PW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  if (DIGITS < 2)         begin : g_bad_digits  $error("DIGITS must be >= 2");         end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout $error("TIMEOUT_CYCLES must be >= 2"); end

  logic [4:0] keys, ev;
  logic       ev_clear, ev_back, ev_enter, ev_change, ev_digit;

  assign keys = {bus.key_clear, bus.key_back, bus.key_enter, bus.key_change, bus.key_digit};
  key_edge #(.W(5)) u_edge (.clk(clk), .rst(rst), .lvl(keys), .rise(ev));
  assign {ev_clear, ev_back, ev_enter, ev_change, ev_digit} = ev;

  entry_state_t  state_q, state_d;
  logic [PW-1:0] pw_q, pw_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          conf_q, conf_d, chg_q, chg_d, err_q, err_d, to_q, to_d;
  logic          acc, to_hit;

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    cnt_d   = cnt_q;
    conf_d  = 1'b0;
    chg_d   = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;
    acc     = 1'b0;
    // Only the highest-priority event is acted on
    if (ev_clear) begin
      acc = 1'b1; pw_d = '0; cnt_d = '0; state_d = IDLE;
    end else if (ev_back) begin
      acc = 1'b1;
      case (state_q)
        DONE:        begin pw_d = '0; cnt_d = '0; state_d = IDLE; end
        ENTRY, FULL: begin
          pw_d    = pw_q >> DIGIT_W;
          cnt_d   = cnt_q - CW'(1);
          state_d = (cnt_q == CW'(1)) ? IDLE : ENTRY;
        end
        default: ;
      endcase
    end else if (ev_enter || ev_change) begin
      if (state_q == FULL || state_q == DONE) begin
        acc = 1'b1; conf_d = ev_enter; chg_d = ~ev_enter; state_d = DONE;
      end else begin
        err_d = 1'b1;
      end
    end else if (ev_digit) begin
      if (bus.key_code > MAX_DIGIT || state_q == FULL) begin
        err_d = 1'b1;
      end else if (state_q == DONE) begin
        acc = 1'b1; pw_d = PW'(bus.key_code); cnt_d = CW'(1); state_d = ENTRY;
      end else begin
        acc     = 1'b1;
        pw_d    = {pw_q[PW-DIGIT_W-1:0], bus.key_code};
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(DIGITS - 1)) ? FULL : ENTRY;
      end
    end
    // An accepted event in the same cycle wins over inactivity
    if (to_hit && !acc) begin
      pw_d = '0; cnt_d = '0; state_d = IDLE; to_d = 1'b1;
    end
  end

`ifdef PASS_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q;

  assign to_hit = (state_q != IDLE) && (tmr_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst)
    if (!rst)                                tmr_q <= '0;
    else if (acc || to_d || state_q == IDLE) tmr_q <= '0;
    else                                     tmr_q <= tmr_q + TW'(1);
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pw_q    <= '0;
      cnt_q   <= '0;
      conf_q  <= 1'b0;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      cnt_q   <= cnt_d;
      conf_q  <= conf_d;
      chg_q   <= chg_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign bus.password    = pw_q;
  assign bus.digit_cnt   = cnt_q;
  assign bus.confirmPass = conf_q;
  assign bus.changePass  = chg_q;
  assign bus.entry_err   = err_q;
  assign bus.timeout     = to_q;
endmodule

// File: tb/tb_pass_entry.sv
// Randomized bench for pass_entry with a digit-queue reference model.
module tb_pass_entry;
  localparam int D  = 4;
  localparam int PW = 4 * D;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pass_entry_if #(.DIGITS(D)) bus ();
  pass_entry #(.DIGITS(D), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: the entry is a queue of digits, oldest first
  int unsigned q[$];
  bit          done = 0;
  bit          mprev[5] = '{0, 0, 0, 0, 0};
  int          idle = 0;
  logic [PW-1:0] e_pw = '0;
  int          e_cnt = 0;
  bit          e_conf = 0, e_chg = 0, e_err = 0, e_to = 0;

  always begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      q.delete(); done = 0; idle = 0;
      mprev = '{0, 0, 0, 0, 0};
      e_conf = 0; e_chg = 0; e_err = 0; e_to = 0;
    end else begin
      bit cur[5];
      bit ev[5];
      bit acc;
      cur = '{bus.key_digit, bus.key_change, bus.key_enter, bus.key_back, bus.key_clear};
      for (int i = 0; i < 5; i++) ev[i] = cur[i] && !mprev[i];
      mprev = cur;
      e_conf = 0; e_chg = 0; e_err = 0; e_to = 0; acc = 0;
      if (ev[4]) begin
        q.delete(); done = 0; acc = 1;
      end else if (ev[3]) begin
        acc = 1;
        if (done) begin q.delete(); done = 0; end
        else if (q.size() > 0) void'(q.pop_back());
      end else if (ev[2] || ev[1]) begin
        if (q.size() == D) begin
          done = 1; acc = 1;
          if (ev[2]) e_conf = 1; else e_chg = 1;
        end else e_err = 1;
      end else if (ev[0]) begin
        if (bus.key_code > 9) e_err = 1;
        else if (done) begin q.delete(); q.push_back(bus.key_code); done = 0; acc = 1; end
        else if (q.size() == D) e_err = 1;
        else begin q.push_back(bus.key_code); acc = 1; end
      end
`ifdef PASS_ENTRY_TIMEOUT_EN
      if (acc || q.size() == 0) idle = 0;
      else if (idle == TO - 1) begin q.delete(); done = 0; idle = 0; e_to = 1; end
      else idle++;
`endif
    end
    e_pw = '0;
    foreach (q[i]) e_pw = (e_pw << 4) | PW'(q[i]);
    e_cnt = q.size();
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("password",    32'(bus.password),    32'(e_pw));
      chk("digit_cnt",   32'(bus.digit_cnt),   32'(e_cnt));
      chk("confirmPass", 32'(bus.confirmPass), 32'(e_conf));
      chk("changePass",  32'(bus.changePass),  32'(e_chg));
      chk("entry_err",   32'(bus.entry_err),   32'(e_err));
      chk("timeout",     32'(bus.timeout),     32'(e_to));
    end
  end

  logic [PW-1:0] s_pw;
  logic [2:0]    s_cnt;
  logic          s_conf, s_chg, s_err;

  task automatic keys_low();
    bus.key_digit = 0; bus.key_enter = 0; bus.key_change = 0;
    bus.key_back  = 0; bus.key_clear = 0;
  endtask

  // k: 0 digit, 1 enter, 2 change, 3 back, 4 clear
  task automatic press(input int k, input logic [3:0] code);
    @(negedge clk);
    bus.key_code = code;
    case (k)
      0: bus.key_digit  = 1;
      1: bus.key_enter  = 1;
      2: bus.key_change = 1;
      3: bus.key_back   = 1;
      default: bus.key_clear = 1;
    endcase
    @(posedge clk); #1;
    s_pw = bus.password; s_cnt = bus.digit_cnt;
    s_conf = bus.confirmPass; s_chg = bus.changePass; s_err = bus.entry_err;
    @(negedge clk);
    keys_low();
  endtask

  task automatic digits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) press(0, v[4*i +: 4]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    keys_low();
    bus.key_code = 0;
    #1;
    chk("reset_pw",  32'(bus.password), 0);
    chk("reset_cnt", 32'(bus.digit_cnt), 0);
    chk("reset_pulses", 32'({bus.confirmPass, bus.changePass, bus.entry_err, bus.timeout}), 0);
    repeat (2) @(negedge clk);
    rst = 1;

    // confirm path
    digits(16'h4781, 4);
    press(1, 0);
    chk("confirm_pw", 32'(s_pw), 32'h4781);
    chk("confirm_cnt", 32'(s_cnt), 4);
    chk("confirm_pulse", 32'(s_conf), 1);
    @(posedge clk); #1;
    chk("confirm_one_cycle", 32'(bus.confirmPass), 0);

    // backspace
    press(4, 0);
    digits(16'h0123, 3);
    press(3, 0);
    press(0, 4'd9);
    chk("back_pw", 32'(s_pw), 32'h0129);
    chk("back_cnt", 32'(s_cnt), 3);
    press(4, 0);
    press(3, 0);
    chk("back_empty_err", 32'(s_err), 0);
    chk("back_empty_cnt", 32'(s_cnt), 0);

    // rejected input
    digits(16'h0012, 2);
    press(1, 0);
    chk("short_enter_err", 32'(s_err), 1);
    chk("short_enter_conf", 32'(s_conf), 0);
    digits(16'h0034, 2);
    press(0, 4'd5);
    chk("fifth_err", 32'(s_err), 1);
    chk("fifth_pw", 32'(s_pw), 32'h1234);
    press(4, 0);
    press(0, 4'hB);
    chk("bad_code_err", 32'(s_err), 1);
    chk("bad_code_cnt", 32'(s_cnt), 0);

    // change then new entry
    digits(16'h2014, 4);
    press(2, 0);
    chk("change_pulse", 32'(s_chg), 1);
    chk("change_conf", 32'(s_conf), 0);
    chk("change_pw", 32'(s_pw), 32'h2014);
    press(0, 4'd5);
    chk("after_done_pw", 32'(s_pw), 32'h0005);
    chk("after_done_cnt", 32'(s_cnt), 1);

    // same-cycle clear and digit
    press(4, 0);
    digits(16'h0067, 2);
    @(negedge clk);
    bus.key_clear = 1; bus.key_digit = 1; bus.key_code = 4'd3;
    @(posedge clk); #1;
    chk("clr_digit_pw", 32'(bus.password), 0);
    chk("clr_digit_cnt", 32'(bus.digit_cnt), 0);
    @(negedge clk); keys_low();

    // held digit key
    @(negedge clk);
    bus.key_digit = 1; bus.key_code = 4'd8;
    repeat (20) @(posedge clk);
    #1;
    chk("held_cnt", 32'(bus.digit_cnt), 1);
    chk("held_pw", 32'(bus.password), 32'h0008);
    @(negedge clk); keys_low();

    // async reset mid-entry, key held through release
    digits(16'h0012, 2);
    @(negedge clk);
    #3 rst = 0;
    #1;
    chk("async_pw", 32'(bus.password), 0);
    chk("async_cnt", 32'(bus.digit_cnt), 0);
    bus.key_digit = 1; bus.key_code = 4'd5;
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("held_rst_pw", 32'(bus.password), 32'h0005);
    chk("held_rst_cnt", 32'(bus.digit_cnt), 1);
    @(negedge clk); keys_low();

`ifdef PASS_ENTRY_TIMEOUT_EN
    press(4, 0);
    press(0, 4'd1);
    @(negedge clk);
    bus.key_digit = 1; bus.key_code = 4'd2;
    @(posedge clk);
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk); keys_low();
      @(posedge clk); #1;
      if (i == TO - 1) chk("to_early", 32'(bus.timeout), 0);
    end
    chk("to_pulse", 32'(bus.timeout), 1);
    chk("to_pw", 32'(bus.password), 0);
    chk("to_cnt", 32'(bus.digit_cnt), 0);
`endif

    // randomized phase
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 2)  == 0) bus.key_digit  = ~bus.key_digit;
      if ($urandom_range(0, 7)  == 0) bus.key_enter  = ~bus.key_enter;
      if ($urandom_range(0, 11) == 0) bus.key_change = ~bus.key_change;
      if ($urandom_range(0, 9)  == 0) bus.key_back   = ~bus.key_back;
      if ($urandom_range(0, 24) == 0) bus.key_clear  = ~bus.key_clear;
      bus.key_code = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
    end
    @(negedge clk); keys_low();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
